// File: rtl/qed_exec_ctrl.sv
// qed_exec_ctrl: controller on the consumer side of the QED instruction cache.
// It decides whether decode sees the original fetch stream (ORIG), the cached
// duplicate stream (DUP) or a QED NOP. It also tracks how many recorded
// originals are still waiting to be replayed, and drives exec_dup into the
// cache.
// Optional feature: define QED_DUP_TIMEOUT_EN to enable the DUP-mode replay
// watchdog. The watchdog sets a sticky qed_err and forces a return to ORIG.
module qed_exec_ctrl #(
  parameter int ICACHESIZE = 16,
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qed_ena,
  input  logic             dup_req,
  input  logic             IF_stall,
  input  logic [31:0]      ifu_instruction,
  input  logic [31:0]      qic_instruction,
  input  logic             qic_vld,
  output logic             exec_dup,
  output logic [31:0]      qed_instruction,
  output logic             qed_vld,
  output logic [CNT_W-1:0] outstanding,
  output logic             qed_err
);

  localparam logic [31:0]      QED_NOP = 32'h0000007F;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(ICACHESIZE - 1);

  // The counter must be able to hold ICACHESIZE-1 without wrapping.
  if ((2 ** CNT_W) <= ICACHESIZE || TIMEOUT < 1) begin : g_param_check
    $error("qed_exec_ctrl: CNT_W too narrow for ICACHESIZE, or TIMEOUT < 1");
  end

  typedef enum logic {
    ORIG = 1'b0,
    DUP  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_hit;
  logic             advance;

  assign advance  = qic_vld & ~IF_stall;
  assign exec_dup = (state == DUP);

`ifdef QED_DUP_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  // Watchdog: counts DUP cycles since the last replay; cleared outside DUP.
  always_ff @(posedge clk) begin
    if (rst || !qed_ena || state != DUP || qic_vld) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + 1'b1;
  end

  // The TIMEOUT-th consecutive DUP cycle without a replay trips the watchdog.
  assign timeout_hit = qed_ena && (state == DUP) && !qic_vld &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

  // Sticky error flag, cleared only by reset or by dropping qed_ena.
  always_ff @(posedge clk) begin
    if (rst || !qed_ena) err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end

  assign qed_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign qed_err     = 1'b0;
`endif

  // Next-state and saturating outstanding-count logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = outstanding;
    if (advance && state == ORIG && outstanding < FULL)
      cnt_nxt = outstanding + 1'b1;
    else if (advance && state == DUP && outstanding != '0)
      cnt_nxt = outstanding - 1'b1;
    case (state)
      ORIG: begin
        // A forced switch on a full cache needs no request.
        if (!IF_stall && outstanding != '0 && (dup_req || outstanding == FULL))
          state_nxt = DUP;
      end
      DUP: begin
        // An empty count in DUP should never happen; recover to ORIG.
        if (outstanding == '0)
          state_nxt = ORIG;
        else if (advance && outstanding == CNT_W'(1))
          state_nxt = ORIG;
      end
      default: state_nxt = ORIG;
    endcase
    if (timeout_hit) begin
      state_nxt = ORIG;
      cnt_nxt   = '0;
    end
  end

  // State and counter registers; a disabled block is held in its reset state.
  always_ff @(posedge clk) begin
    if (rst || !qed_ena) begin
      state       <= ORIG;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= cnt_nxt;
    end
  end

  // Issue mux to decode: pass-through, original, duplicate or NOP.
  always_comb begin
    qed_instruction = QED_NOP;
    qed_vld         = 1'b0;
    if (!qed_ena) begin
      qed_instruction = ifu_instruction;
      qed_vld         = ~IF_stall;
    end else if (advance && state == ORIG) begin
      qed_instruction = ifu_instruction;
      qed_vld         = 1'b1;
    end else if (advance && state == DUP) begin
      qed_instruction = qic_instruction;
      qed_vld         = 1'b1;
    end
  end

endmodule

// File: doc/qed_exec_ctrl.md
Name: qed_exec_ctrl

Overview:
- Consumer and controller on the far side of the QED instruction cache.
- Drives exec_dup into the cache.
- Tracks how many original instructions are cached and not yet replayed.
- Selects the instruction issued to decode: the original fetch stream in ORIG mode, the cache replay stream in DUP mode, or a QED NOP.
- Sits between the fetch unit / QED instruction cache and the decode stage.

Parameters:
- ICACHESIZE, 16: depth of the paired QED instruction cache. Outstanding-count full threshold = ICACHESIZE-1.
- CNT_W, 8: width of the outstanding counter. Must satisfy 2^CNT_W > ICACHESIZE.
- TIMEOUT, 64: max cycles in DUP without a replay before error. Used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- qed_ena  input  1  QED mode enable; 0 = transparent pass-through
- dup_req  input  1  request to switch from ORIG to DUP (free input for formal)
- IF_stall  input  1  fetch stall
- ifu_instruction  input  32  original fetched instruction
- qic_instruction  input  32  cache output (cache's qic_qimux_instruction)
- qic_vld  input  1  cache insert/delete happened this cycle (cache's vld_out)
- exec_dup  output  1  to cache: 1 = replay duplicates, 0 = record originals
- qed_instruction  output  32  instruction to decode
- qed_vld  output  1  qed_instruction is a real (non-NOP) instruction
- outstanding  output  CNT_W  originals recorded minus duplicates replayed
- qed_err  output  1  sticky error

Behaviour:
- Reset, synchronous: state=ORIG, outstanding=0, exec_dup=0, qed_err=0.
  - Reset dominates any same-cycle event.
  - Reset mid-DUP abandons the replay; the cache is reset by the same rst.
- Constant QED_NOP = 32'h0000007F (opcode field 7'b1111111).
- exec_dup is registered: exec_dup = (state==DUP).
- FSM states: ORIG, DUP.
  - ORIG->DUP when ~IF_stall and outstanding!=0 and either:
    - dup_req=1, or
    - outstanding==ICACHESIZE-1 (forced switch on cache full).
  - DUP->ORIG when ~IF_stall and qic_vld and outstanding==1 (last replay). exec_dup falls the next cycle.
  - DUP with outstanding==0 is unreachable. If detected, return to ORIG.
  - dup_req in DUP is ignored.
  - dup_req with outstanding==0 is ignored and the block stays in ORIG.
- Counter:
  - +1 when state==ORIG & qic_vld & ~IF_stall.
  - -1 when state==DUP & qic_vld & ~IF_stall.
  - Never both in one cycle.
  - Saturates: no increment at ICACHESIZE-1, no decrement at 0.
  - Mod-2^CNT_W wrap is never permitted.
- Output mux (combinational, same cycle as inputs):
  - qed_ena=0: qed_instruction=ifu_instruction; qed_vld=~IF_stall. FSM and counter are held at reset values.
  - ORIG, qic_vld=1: qed_instruction=ifu_instruction (original issued alongside its cached QED copy); qed_vld=1.
  - DUP, qic_vld=1: qed_instruction=qic_instruction; qed_vld=1.
  - Otherwise (stall, NOP fetch, cache full, cache empty): qed_instruction=QED_NOP; qed_vld=0.
- qed_ena dropping to 0 mid-operation: state, counter and error are cleared next cycle, as for reset.

Optional Feature:
- Macro QED_DUP_TIMEOUT_EN.
- Defined:
  - A 7-bit-min stall counter runs in DUP. It clears on each replay (qic_vld) and on leaving DUP, and increments otherwise.
  - On reaching TIMEOUT it sets qed_err=1 (sticky until rst) and forces state to ORIG, with outstanding=0 next cycle.
- Not defined: qed_err tied to 0; no counter logic.

Test Plan:
- Reset then qed_ena=1; 3 non-stalled fetches with qic_vld=1, dup_req=0 -> outstanding=3, exec_dup=0, qed_instruction equals each ifu_instruction, qed_vld=1 each cycle.
- From outstanding=3, pulse dup_req=1 one cycle -> exec_dup=1 next cycle. Three qic_vld cycles forward qic_instruction values A,B,C. outstanding steps 2,1,0. exec_dup=0 the cycle after C.
- Record 15 instructions (ICACHESIZE-1) with dup_req=0 -> forced DUP: exec_dup=1 with outstanding=15, counter not incremented past 15.
- IF_stall=1 for 4 cycles in DUP with qic_vld=1 -> outstanding unchanged, qed_instruction=32'h0000007F, qed_vld=0.
- dup_req=1 with outstanding=0 -> stays ORIG, exec_dup=0. rst asserted in DUP at outstanding=2 -> next cycle exec_dup=0, outstanding=0.
- With QED_DUP_TIMEOUT_EN: enter DUP at outstanding=2, hold qic_vld=0 for 64 cycles -> qed_err=1, state ORIG, outstanding=0, qed_err stays 1 until rst.
